// File: rtl/sqrt_arbiter.sv
// Purpose  : round-robin sharing of one pipelined sqrt unit among REQUESTERS ports.
// Latency  : grant in cycle t -> rsp_valid in cycle t+LATENCY+2.
// Backpress: one op outstanding per requester; a held result blocks that requester's next grant.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req_a/valid/ready   per-requester operand port (req_ready is combinational)
//   rsp_z/valid/ready   per-requester registered result port
//   sqrt_a / sqrt_z     registered operand to, and result from, the shared sqrt pipeline
module sqrt_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQUESTERS*WIDTH-1:0]   req_a,
  input  logic [REQUESTERS-1:0]         req_valid,
  output logic [REQUESTERS-1:0]         req_ready,
  output logic [REQUESTERS*WIDTH-1:0]   rsp_z,
  output logic [REQUESTERS-1:0]         rsp_valid,
  input  logic [REQUESTERS-1:0]         rsp_ready,
  output logic [WIDTH-1:0]              sqrt_a,
  input  logic [WIDTH-1:0]              sqrt_z
);

  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  typedef logic [IW-1:0] idx_t;

  logic [REQUESTERS-1:0]       r_busy;
  idx_t                        r_rr;
  logic [WIDTH-1:0]            r_sqrt_a;
  logic [LATENCY:0]            r_tag_vld;
  idx_t                        r_tag_idx [LATENCY+1];
  logic [REQUESTERS*WIDTH-1:0] r_rsp_z;
  logic [REQUESTERS-1:0]       r_rsp_vld;

  logic [REQUESTERS-1:0]       w_elig;
  logic                        w_gnt_vld;
  idx_t                        w_gnt_idx;
  int                          w_cand;
  logic [WIDTH-1:0]            w_gnt_a;

  // Search rr, rr+1, ... wrapping; first eligible requester wins.
  // Grants are suppressed while rst is high.
  always_comb begin
    w_elig    = req_valid & ~r_busy;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = 0;
    for (int off = 0; off < REQUESTERS; off++) begin
      w_cand = int'(r_rr) + off;
      if (w_cand >= REQUESTERS) w_cand = w_cand - REQUESTERS;
      if (!w_gnt_vld && !rst && w_elig[idx_t'(w_cand)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx_t'(w_cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_gnt_vld) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_gnt_a = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];

  // Issue path and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr     <= '0;
      r_sqrt_a <= '0;
    end else begin
      // Bubbles carry zero; their results are never captured.
      r_sqrt_a <= w_gnt_vld ? w_gnt_a : '0;
      if (w_gnt_vld) begin
        r_rr <= (w_gnt_idx == idx_t'(REQUESTERS-1)) ? '0 : idx_t'(w_gnt_idx + 1'b1);
      end
    end
  end

  // Tag delay line: stage LATENCY lines up with sqrt_z for the same operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_gnt_vld};
    end
    r_tag_idx[0] <= w_gnt_idx;
    for (int s = 1; s <= LATENCY; s++) begin
      r_tag_idx[s] <= r_tag_idx[s-1];
    end
  end

  // Result capture, response handshake and busy tracking per requester.
  // busy cannot set and clear together: a busy requester is never granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_rsp_vld <= '0;
      r_rsp_z   <= '0;
    end else begin
      for (int k = 0; k < REQUESTERS; k++) begin
        if (r_tag_vld[LATENCY] && (r_tag_idx[LATENCY] == idx_t'(k))) begin
          r_rsp_z[k*WIDTH +: WIDTH] <= sqrt_z;
          r_rsp_vld[k]              <= 1'b1;
        end else if (rsp_ready[k]) begin
          r_rsp_vld[k] <= 1'b0;
        end

        if (w_gnt_vld && (w_gnt_idx == idx_t'(k))) begin
          r_busy[k] <= 1'b1;
        end else if (r_rsp_vld[k] && rsp_ready[k]) begin
          r_busy[k] <= 1'b0;
        end
      end
    end
  end

  assign sqrt_a    = r_sqrt_a;
  assign rsp_z     = r_rsp_z;
  assign rsp_valid = r_rsp_vld;

endmodule
